// File: rtl/int_ctrl.sv
// Vectored, prioritized interrupt controller with edge latching and masking.
// Optional nesting of higher-priority sources enabled by defining INT_NEST_EN.
module int_ctrl #(
  parameter int               IDW        = 2,
  parameter int               VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int               VEC_STRIDE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2**IDW-1:0]   irq,
  input  logic                mask_we,
  input  logic [2**IDW-1:0]   mask_in,
  input  logic                int_ack,
  input  logic                reti,
  output logic                int_req,
  output logic [IDW-1:0]      int_id,
  output logic [VEC_W-1:0]    int_vec,
  output logic [2**IDW-1:0]   pending,
  output logic [2**IDW-1:0]   isr,
  output logic [2**IDW-1:0]   mask
);

  localparam int NSRC = 2**IDW;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [NSRC-1:0]   irq_q;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   elig;
  logic [NSRC-1:0]   ackclr;
  logic [NSRC-1:0]   isr_lo;
  logic [NSRC-1:0]   pending_nx;
  logic [NSRC-1:0]   isr_nx;
  logic              cand_vld;
  logic [IDW-1:0]    cand_id;
  logic [IDW-1:0]    isr_id;
  logic [VEC_W-1:0]  cand_vec;
  logic              allow;
  logic              take;
  logic              ack_fire;

  assign rise     = irq & ~irq_q;
  assign elig     = pending & ~mask;
  assign isr_lo   = isr & (~isr + NSRC'(1));
  assign ack_fire = (state == REQ) && int_ack;
  assign ackclr   = ack_fire ? (NSRC'(1) << int_id) : '0;
  assign take     = (state == IDLE) && cand_vld && allow;
  assign int_req  = (state == REQ);
  assign cand_vec =
    VEC_W'(int'(VEC_BASE) + int'(cand_id) * VEC_STRIDE);

  assign pending_nx = (pending & ~ackclr) | rise;
  assign isr_nx     = (reti ? (isr & ~isr_lo) : isr) | ackclr;

  // Lowest-index eligible source wins.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (elig[i]) begin
        cand_vld = 1'b1;
        cand_id  = IDW'(i);
      end
    end
  end

  // Index of the highest-priority handler in service.
  always_comb begin
    isr_id = '0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (isr[i]) isr_id = IDW'(i);
    end
  end

  // Request rule: only preempt a running handler when nesting is built in.
  always_comb begin
`ifdef INT_NEST_EN
    allow = (isr == '0) || (cand_id < isr_id);
`else
    allow = (isr == '0);
`endif
  end

  // Request handshake sequencing.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = REQ;
      REQ:     if (int_ack) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, edge latches, mask and frozen request id/vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      irq_q   <= '0;
      pending <= '0;
      isr     <= '0;
      mask    <= '1;
      int_id  <= '0;
      int_vec <= VEC_BASE;
    end else begin
      state   <= state_nx;
      irq_q   <= irq;
      pending <= pending_nx;
      isr     <= isr_nx;
      if (mask_we) mask <= mask_in;
      if (take) begin
        int_id  <= cand_id;
        int_vec <= cand_vec;
      end
    end
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Vectored, prioritized interrupt controller for the single-cycle CPU. It latches rising edges on up to 2**IDW external interrupt lines, applies a software-written mask, and raises one request at a time to the control unit. It supplies the handler vector, and tracks which handlers are in service until their return-from-interrupt. The control unit performs the PC push/jump with the existing stack path (push/pop, wesp) and only handshakes with this block.

## Interface
Parameters:
- IDW, 2: source-id width; NSRC = 2**IDW sources
- VEC_W, 10: vector (PC) width
- VEC_BASE, 10'h3C0: vector of source 0
- VEC_STRIDE, 4: vector spacing; vector = VEC_BASE + id*VEC_STRIDE, truncated to VEC_W bits

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- irq  in  NSRC  interrupt lines, rising-edge triggered, synchronous to clk
- mask_we  in  1  write strobe for mask register
- mask_in  in  NSRC  new mask value, 1 = source masked
- int_ack  in  1  one-cycle pulse from control unit: PC pushed, jump to int_vec taken
- reti  in  1  one-cycle pulse: return-from-interrupt executed
- int_req  out  1  registered request to control unit
- int_id  out  IDW  id of requested source, valid while int_req=1
- int_vec  out  VEC_W  handler address, valid while int_req=1
- pending  out  NSRC  latched, not-yet-acknowledged edges (status read)
- isr  out  NSRC  in-service bitmap
- mask  out  NSRC  current mask

## Operation
- Reset (reset=0 at an edge): irq_q=0, pending=0, isr=0, mask=all ones, state=IDLE, int_req=0, int_id=0, int_vec=VEC_BASE.
- Edge detect: rise = irq & ~irq_q; pending <= (pending & ~ackclr) | rise. On the same bit in the same cycle, set wins over ack clear.
- mask_we loads mask_in at the edge. A mask change never withdraws an asserted int_req.
- Eligible = pending & ~mask. The candidate is the lowest-index eligible bit, and lower index means higher priority.
- FSM states:
  - IDLE: if a candidate exists and the request rule allows it, latch id/vec and go to REQ.
  - REQ: int_req=1, int_id/int_vec frozen. On int_ack: clear pending[id], set isr[id], go to GAP.
  - GAP: one cycle with int_req=0 so the first handler instruction executes, then go to IDLE.
- reti: clears the lowest set bit of isr. If isr=0, reti is ignored. For simultaneous reti and int_ack, reti applies to the old isr first, then the ack bit is set.
- int_ack outside REQ and reti in any state other than as above: no FSM effect.

## Timing
- irq low at edge k-1 and high at edge k: pending bit visible after edge k. REQ/int_req=1 after edge k+1 if the rule allows, so latency is 2 cycles.
- int_req is held until int_ack. There is no timeout.
- After ack, the earliest next int_req is 2 edges later (GAP, then IDLE→REQ).
- An edge on a source already pending is absorbed. There is no counting.
- Reset asserted mid-REQ or in service drops int_req on that edge and clears all state.

## Configuration
- INT_NEST_EN defined: the request rule is "isr==0, or candidate index < index of lowest set isr bit". A higher-priority source preempts a running handler, and isr can hold multiple bits.
- INT_NEST_EN undefined: the request rule is "isr==0". No request is raised while any handler is in service, and at most one isr bit is ever set.

## Test plan
- Reset, mask_in=4'b0000 written, irq[2] rises at edge 5 → int_req=1 after edge 6, int_id=2, int_vec=0x3C8. Pulse int_ack → pending=0, isr=4'b0100, int_req=0 next cycle.
- irq[1] and irq[3] rise together with mask=0 → int_id=1 first. After ack and reti, a second request appears with int_id=3 and int_vec=0x3CC.
- mask=4'b0010, irq[1] rises → no int_req, pending=4'b0010. Writing mask=0 → int_req 1 cycle after the write edge, int_id=1.
- In service on id 2, irq[0] rises: with INT_NEST_EN, int_req with id 0, and after ack isr=4'b0101; reti → 4'b0100. Without INT_NEST_EN, no request until reti, then id 0 is requested.
- irq[3] re-rises on the same cycle as int_ack for id 3 → pending[3] stays 1 and isr[3]=1.
- reset=0 while int_req=1 → after that edge int_req=0, pending=isr=0, mask=4'b1111.
